// File: rtl/mem_arbiter_if.sv
// Bundles the L1-side request/response wires and the memory-side handshake of mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding caches and memory.
interface mem_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 512,
    parameter int IDX_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LINE_BITS-1:0]  req_wline;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [LINE_BITS-1:0]          resp_rline;
    logic                          busy;
    logic [IDX_W-1:0]              grant_id;
    logic                          mem_req;
    logic                          mem_wr;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [LINE_BITS-1:0]          mem_wline;
    logic                          mem_ready;
    logic [LINE_BITS-1:0]          mem_rline;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wline, mem_ready, mem_rline,
        output resp_ready, resp_rline, busy, grant_id, mem_req, mem_wr, mem_addr, mem_wline
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wline, mem_ready, mem_rline,
        input  resp_ready, resp_rline, busy, grant_id, mem_req, mem_wr, mem_addr, mem_wline
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising L1 line fills/writebacks onto one memory; mem_req 1 cycle after grant,
// resp_ready 1 cycle after mem_ready; requesters are back-pressured by holding req_valid until their pulse.
module mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 512,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MEM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]   mem_wline_q, mem_wline_d;
    logic                   busy_q, busy_d;
    logic [NUM_REQ-1:0]     resp_ready_q, resp_ready_d;
    logic [LINE_BITS-1:0]   resp_rline_q, resp_rline_d;

    logic                   win_vld;
    logic [IDX_W-1:0]       win_idx;
    int                     cand;

    // First pending requester scanning upward from rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_vld && bus.req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        mem_req_d    = 1'b0;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wline_d  = mem_wline_q;
        busy_d       = busy_q;
        resp_ready_d = '0;
        resp_rline_d = resp_rline_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_id_d  = win_idx;
                    mem_wr_d    = bus.req_wr[win_idx];
                    mem_addr_d  = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wline_d = bus.req_wline[int'(win_idx)*LINE_BITS +: LINE_BITS];
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (bus.mem_ready) begin
                    resp_rline_d             = bus.mem_rline;
                    resp_ready_d[grant_id_q] = 1'b1;
                    rr_ptr_d                 = IDX_W'((int'(grant_id_q) + 1) % NUM_REQ);
                    state_d                  = DONE;
                end
            end
            DONE: begin
                // req_valid is deliberately ignored here so the winner can drop it on the pulse edge.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wline_q  <= '0;
            busy_q       <= 1'b0;
            resp_ready_q <= '0;
            resp_rline_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wline_q  <= mem_wline_d;
            busy_q       <= busy_d;
            resp_ready_q <= resp_ready_d;
            resp_rline_q <= resp_rline_d;
        end
    end

    assign bus.resp_ready = resp_ready_q;
    assign bus.resp_rline = resp_rline_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wline  = mem_wline_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural line memory, transaction-level round-robin model,
// directed scenarios followed by randomized traffic from both requesters.
module tb_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LB = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_BITS(LB)) bus();
    mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_BITS(LB)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { bit wr; logic [LB-1:0] line; } exp_t;

    int checks   = 0;
    int failures = 0;

    exp_t          exp_q [N][$];
    logic [LB-1:0] golden [int];
    logic [LB-1:0] dev_mem [int];
    logic [LB-1:0] last_rline [N];
    int            grant_log [$];
    int            fixed_lat = 0;
    bit            stray_en  = 1'b0;

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Memory preload: 32-bit word k of the address space holds k.
    function automatic logic [LB-1:0] pat(input int line);
        logic [LB-1:0] r;
        for (int j = 0; j < LB/32; j++) r[j*32 +: 32] = 32'(line*16 + j);
        return r;
    endfunction

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] r;
        for (int j = 0; j < LB/32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural memory: latches a request on mem_req, answers after a latency with a one-cycle mem_ready.
    initial begin
        int cnt = 0;
        int line = 0;
        bit wr = 1'b0;
        logic [LB-1:0] wl = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rline = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = stray_en;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mem_ready = 1'b1;
                        if (wr) begin
                            dev_mem[line] = wl;
                            bus.mem_rline = wl;
                        end else begin
                            bus.mem_rline = dev_mem.exists(line) ? dev_mem[line] : pat(line);
                        end
                    end
                end
                if (bus.mem_req) begin
                    line = int'(bus.mem_addr >> 6);
                    wr   = bus.mem_wr;
                    wl   = bus.mem_wline;
                    cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
                end
            end
        end
    end

    // Monitor: transaction-level arbiter model, checked every falling edge.
    initial begin
        bit            model_idle = 1'b1;
        int            model_rr   = 0;
        bit            waiting    = 1'b0;
        bit            exp_mreq   = 1'b0;
        bit            exp_resp   = 1'b0;
        int            exp_g      = 0;
        logic [AW-1:0] exp_addr   = '0;
        bit            exp_wr     = 1'b0;
        logic [LB-1:0] exp_wline  = '0;
        logic [N-1:0]  exp_rr;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", LB'({bus.busy, bus.mem_req, bus.resp_ready, bus.grant_id, bus.mem_wr,
                    |bus.mem_addr, |bus.mem_wline, |bus.resp_rline}), '0);
                model_idle = 1'b1; model_rr = 0; waiting = 1'b0; exp_mreq = 1'b0; exp_resp = 1'b0;
                for (int i = 0; i < N; i++) exp_q[i].delete();
            end else begin
                chk("mem_req", LB'(bus.mem_req), LB'(exp_mreq));
                if (exp_mreq) begin
                    grant_log.push_back(int'(bus.grant_id));
                    chk("grant_id", LB'(bus.grant_id), LB'(exp_g));
                    chk("mem_addr", LB'(bus.mem_addr), LB'(exp_addr));
                    chk("mem_wr", LB'(bus.mem_wr), LB'(exp_wr));
                    chk("mem_wline", bus.mem_wline, exp_wline);
                    waiting = 1'b1;
                end
                exp_rr = exp_resp ? N'(1 << exp_g) : '0;
                chk("resp_ready", LB'(bus.resp_ready), LB'(exp_rr));
                if (exp_resp && bus.resp_ready[exp_g]) begin
                    last_rline[exp_g] = bus.resp_rline;
                    if (exp_q[exp_g].size() == 0) begin
                        chk("scoreboard_empty", LB'(1), LB'(0));
                    end else begin
                        e = exp_q[exp_g].pop_front();
                        if (!e.wr) chk("resp_rline", bus.resp_rline, e.line);
                    end
                end
                chk("busy", LB'(bus.busy), LB'(!model_idle));

                exp_mreq = 1'b0;
                if (exp_resp) begin
                    model_rr   = (exp_g + 1) % N;
                    model_idle = 1'b1;
                    exp_resp   = 1'b0;
                end else if (model_idle && |bus.req_valid) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (bus.req_valid[(model_rr + k) % N]) exp_g = (model_rr + k) % N;
                    exp_addr   = bus.req_addr[exp_g*AW +: AW];
                    exp_wr     = bus.req_wr[exp_g];
                    exp_wline  = bus.req_wline[exp_g*LB +: LB];
                    exp_mreq   = 1'b1;
                    model_idle = 1'b0;
                end
                if (waiting && !exp_mreq && bus.mem_ready) begin
                    exp_resp = 1'b1;
                    waiting  = 1'b0;
                end
            end
        end
    end

    // One transaction on requester i: push the expected response, present it, wait for its pulse.
    task automatic do_req(input int i, input bit wr, input logic [AW-1:0] addr, input logic [LB-1:0] wl);
        exp_t e;
        int   line = int'(addr >> 6);
        bit   got  = 1'b0;
        e.wr   = wr;
        e.line = golden.exists(line) ? golden[line] : pat(line);
        if (wr) golden[line] = wl;
        exp_q[i].push_back(e);
        bus.req_addr[i*AW +: AW]  = addr;
        bus.req_wr[i]             = wr;
        bus.req_wline[i*LB +: LB] = wl;
        bus.req_valid[i]          = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = bus.resp_ready[i];
        end
        if (!got) chk($sformatf("timeout_req%0d", i), LB'(0), LB'(1));
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic run_rand(input int i, input int n);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            do_req(i, 1'($urandom_range(0, 1)),
                   AW'((200 + i*40 + int'($urandom_range(0, 7))) * 64 + int'($urandom_range(0, 63))),
                   rnd_line());
        end
    endtask

    task automatic chk_log(input string nm, input int a0, input int a1, input int a2);
        int req[3];
        req[0] = a0; req[1] = a1; req[2] = a2;
        chk({nm, "_count"}, LB'(grant_log.size()), LB'(3));
        for (int k = 0; k < 3 && k < grant_log.size(); k++)
            chk($sformatf("%s_%0d", nm, k), LB'(grant_log[k]), LB'(req[k]));
        grant_log.delete();
    endtask

    initial begin
        bit fired;
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wline = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_req(0, 1'b0, 32'h0000_0040, '0);
        chk("read40_word0", LB'(last_rline[0][31:0]), LB'(32'h10));

        do_req(1, 1'b1, 32'h0000_0080, {16{32'hA5A5A5A5}});
        do_req(1, 1'b0, 32'h0000_0084, '0);
        chk("rd_after_wr", last_rline[1], {16{32'hA5A5A5A5}});
        grant_log.delete();

        fork
            do_req(0, 1'b0, 32'h0000_1000, '0);
            do_req(1, 1'b0, 32'h0000_2000, '0);
        join
        do_req(0, 1'b0, 32'h0000_1040, '0);
        chk_log("simul_a", 0, 1, 0);
        fork
            do_req(0, 1'b0, 32'h0000_1080, '0);
            do_req(1, 1'b0, 32'h0000_2040, '0);
        join
        chk("simul_b_first", LB'(grant_log.size() > 0 ? grant_log[0] : -1), LB'(1));
        chk("simul_b_second", LB'(grant_log.size() > 1 ? grant_log[1] : -1), LB'(0));
        grant_log.delete();

        fixed_lat = 8;
        fork
            begin
                do_req(0, 1'b0, 32'h0000_1100, '0);
                do_req(0, 1'b1, 32'h0000_1140, rnd_line());
            end
            begin
                repeat (4) @(posedge clk);
                #1 do_req(1, 1'b0, 32'h0000_2100, '0);
            end
        join
        chk_log("fair", 0, 1, 0);

        fixed_lat = 20;
        bus.req_addr[0 +: AW] = 32'h0000_0300;
        bus.req_wr[0]         = 1'b0;
        bus.req_valid[0]      = 1'b1;
        fired = 1'b0;
        for (int c = 0; c < 20 && !fired; c++) begin
            @(negedge clk);
            fired = bus.mem_req;
        end
        chk("rst_test_issue", LB'(fired), LB'(1));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_zero", LB'({bus.busy, bus.mem_req, bus.resp_ready, bus.grant_id, bus.mem_wr,
                |bus.mem_addr, |bus.mem_wline, |bus.resp_rline}), '0);
        bus.req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fixed_lat = 0;
        repeat (3) @(posedge clk);
        #1 do_req(0, 1'b0, 32'h0000_0040, '0);
        chk("post_rst_read", LB'(last_rline[0][31:0]), LB'(32'h10));

        @(negedge clk) stray_en = 1'b1;
        repeat (3) @(negedge clk);
        stray_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fork
            run_rand(0, 40);
            run_rand(1, 40);
        join
        repeat (4) @(posedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("drain_q%0d", i), LB'(exp_q[i].size()), LB'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
